// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the game-round controller.
//   state_e       4-bit state codes decoded by the display/sound blocks
//   JUDG_*        judge result codes on JUDG_IN
//   HP_*          hit-point result codes on HP_IN
//   ms_to_cycles  converts a millisecond count into clock cycles
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_READY    = 4'b0010,
    ST_QUESTION = 4'b0011,
    ST_INPUT    = 4'b0100,
    ST_DRAW     = 4'b0110,
    ST_WRONG    = 4'b0111,
    ST_GOOD     = 4'b1000,
    ST_OUCH     = 4'b1001,
    ST_WIN      = 4'b1010,
    ST_LOSE     = 4'b1011,
    ST_TIMEOUT  = 4'b1100
  } state_e;

  localparam logic [1:0] JUDG_GOOD = 2'b01;
  localparam logic [1:0] JUDG_OUCH = 2'b10;
  localparam logic [1:0] JUDG_DRAW = 2'b11;

  localparam logic [1:0] HP_WIN  = 2'b01;
  localparam logic [1:0] HP_LOSE = 2'b10;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/ms_tick_timer.sv
// ms_tick_timer: millisecond prescaler feeding a ms down-counter.
//   CLK       system clock
//   RST_N     asynchronous active-low reset
//   load_i    restart: prescaler to 0, counter to dur_i, busy set
//   dur_i     duration in ms (>=1) captured on load_i
//   clr_i     abandon the current count (busy cleared)
//   expire_o  1-cycle pulse on the ms tick where the counter reaches 0
//   busy_o    high from load until expiry
module ms_tick_timer #(
  parameter int unsigned TICK_CYC = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load_i,
  input  logic [CNT_W-1:0] dur_i,
  input  logic             clr_i,
  output logic             expire_o,
  output logic             busy_o
);

  localparam int unsigned PRE_W = $clog2(TICK_CYC + 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             tick;

  assign tick     = (pre_q == PRE_W'(TICK_CYC - 1));
  // Counter holds ms remaining including the current one, so it hits 0
  // on the tick where it reads 1.
  assign expire_o = busy_q & tick & (cnt_q == CNT_W'(1));
  assign busy_o   = busy_q;

  always_comb begin
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (load_i) begin
      pre_d  = '0;
      cnt_d  = dur_i;
      busy_d = 1'b1;
    end else if (clr_i) begin
      pre_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (busy_q) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
      if (tick) cnt_d = cnt_q - CNT_W'(1);
      if (expire_o) busy_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/round_ctrl_fsm.sv
// round_ctrl_fsm: game-round sequencer READY -> QUESTION -> INPUT -> result.
//   CLK, RST_N   clock, asynchronous active-low reset
//   READY_IN     player-ready level, registered to READY_OUT while in READY
//   OK_IN, QUE   start request / question valid
//   QUE_IN       question-phase level, rising/falling edges used
//   JUDG_IN      judge result, WRONG_IN malformed-answer pulse, HP_IN hp result
//   STATE        state register, ROUND_CNT questions started this game
//   WRONG_CNT    wrong answers on this question, TIMER_BUSY timed state counting
//
// state    | meaning
// READY    | waiting for OK_IN & QUE
// QUESTION | question shown, waiting for QUE_IN rise
// INPUT    | accepting answer (answer timeout when ANSWER_MS>0)
// WRONG    | malformed answer shown for WRONG_MS
// GOOD     | correct answer shown, may escalate to WIN
// OUCH     | hit taken, may escalate to LOSE
// DRAW     | draw shown
// TIMEOUT  | answer timed out, may escalate to LOSE
// WIN/LOSE | game over shown, round count cleared on exit
module round_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned HOLD_MS   = 1000,
  parameter int unsigned WRONG_MS  = 1000,
  parameter int unsigned ANSWER_MS = 10000,
  parameter int unsigned MAX_WRONG = 3,
  parameter int unsigned ROUND_W   = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               READY_IN,
  input  logic               OK_IN,
  input  logic               QUE,
  input  logic               QUE_IN,
  input  logic [1:0]         JUDG_IN,
  input  logic               WRONG_IN,
  input  logic [1:0]         HP_IN,
  output logic               READY_OUT,
  output logic [3:0]         STATE,
  output logic [ROUND_W-1:0] ROUND_CNT,
  output logic [3:0]         WRONG_CNT,
  output logic               TIMER_BUSY
);

  localparam int unsigned TICK_CYC = ms_to_cycles(CLK_HZ, 1);
  localparam int unsigned MAX_HW   = (HOLD_MS > WRONG_MS) ? HOLD_MS : WRONG_MS;
  localparam int unsigned MAX_MS   = (MAX_HW > ANSWER_MS) ? MAX_HW : ANSWER_MS;
  localparam int unsigned CNT_W    = $clog2(MAX_MS + 1);

  state_e             state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic               ready_q, ready_d;
  logic               qr_q;
  logic               rise, fall;
  logic               expire, busy, load, clr;
  logic [CNT_W-1:0]   dur;

  function automatic logic is_timed(input state_e s);
    case (s)
      ST_WRONG, ST_GOOD, ST_OUCH, ST_DRAW,
      ST_WIN, ST_LOSE, ST_TIMEOUT: return 1'b1;
      ST_INPUT:                    return (ANSWER_MS != 0);
      default:                     return 1'b0;
    endcase
  endfunction

  assign rise = QUE_IN & ~qr_q;
  assign fall = ~QUE_IN & qr_q;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    wcnt_d  = wcnt_q;
    ready_d = ready_q;
    case (state_q)
      ST_READY: begin
        ready_d = READY_IN;
        if (OK_IN && QUE) begin
          state_d = ST_QUESTION;
          round_d = round_q + ROUND_W'(1);
        end
      end
      ST_QUESTION: begin
        if (rise && QUE) begin
          state_d = ST_INPUT;
          wcnt_d  = '0;
        end
      end
      ST_INPUT: begin
        if (fall && QUE) state_d = ST_QUESTION;
        else if (WRONG_IN) begin
          state_d = ST_WRONG;
          if (wcnt_q != 4'd15) wcnt_d = wcnt_q + 4'd1;
        end
        else if (JUDG_IN == JUDG_GOOD) state_d = ST_GOOD;
        else if (JUDG_IN == JUDG_OUCH) state_d = ST_OUCH;
        else if (JUDG_IN == JUDG_DRAW) state_d = ST_DRAW;
        else if (expire) state_d = ST_TIMEOUT;
      end
      ST_WRONG: begin
        if (expire) begin
          if (MAX_WRONG != 0 && 32'(wcnt_q) >= 32'(MAX_WRONG)) state_d = ST_OUCH;
          else state_d = ST_INPUT;
        end
      end
      ST_GOOD: begin
        if (HP_IN == HP_WIN) state_d = ST_WIN;
        else if (expire) state_d = ST_READY;
      end
      ST_OUCH, ST_TIMEOUT: begin
        if (HP_IN == HP_LOSE) state_d = ST_LOSE;
        else if (expire) state_d = ST_READY;
      end
      ST_DRAW: begin
        if (expire) state_d = ST_READY;
      end
      ST_WIN, ST_LOSE: begin
        if (expire) begin
          state_d = ST_READY;
          round_d = '0;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  // Every timed state is entered from a different state, so a change of
  // state into a timed one is exactly the reload condition.
  assign load = is_timed(state_d) && (state_d != state_q);
  assign clr  = !is_timed(state_d);

  always_comb begin
    dur = CNT_W'(HOLD_MS);
    if (state_d == ST_WRONG) dur = CNT_W'(WRONG_MS);
    else if (state_d == ST_INPUT) dur = CNT_W'(ANSWER_MS);
  end

  ms_tick_timer #(
    .TICK_CYC (TICK_CYC),
    .CNT_W    (CNT_W)
  ) u_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load_i   (load),
    .dur_i    (dur),
    .clr_i    (clr),
    .expire_o (expire),
    .busy_o   (busy)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_READY;
      round_q <= '0;
      wcnt_q  <= '0;
      ready_q <= 1'b0;
      qr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      wcnt_q  <= wcnt_d;
      ready_q <= ready_d;
      qr_q    <= QUE_IN;
    end
  end

  assign STATE      = state_q;
  assign ROUND_CNT  = round_q;
  assign WRONG_CNT  = wcnt_q;
  assign READY_OUT  = ready_q;
  assign TIMER_BUSY = busy;

endmodule
